uart_rx_controller: RTL and testbench
=====================================

Name: uart_rx_controller

Overview:
Receive-side sequencer for the UART. It runs on the oversampling sample enable from the baud generator and synchronises RxD. The FSM detects and qualifies the start bit, then samples each data, parity and stop bit at mid-bit. It assembles the byte and reports data, valid, parity error and framing error to the system side.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8), LSB first
OVERSAMPLE, 16, sample enables per bit period (even, 8..32)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
Rx_EN  input  1  receiver enable; 0 forces IDLE and clears the internal sample counter
Rx_sample_ENABLE  input  1  one-clk pulse at OVERSAMPLE x baud rate
parity_odd  input  1  1 = odd parity, 0 = even; sampled at frame start
RxD  input  1  serial line, asynchronous, idle high
Rx_DATA  output  DATA_BITS  last received word
Rx_VALID  output  1  one-clk pulse when a frame completes
Rx_PERROR  output  1  parity error flag for the last frame
Rx_FERROR  output  1  framing error flag for the last frame (stop bit = 0)
Rx_BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high) values: Rx_DATA=0, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0, Rx_BUSY=0, FSM=IDLE, sample counter=0, synchroniser flops=1.
- RxD passes through a 2-flop synchroniser to give rxd_s. All decisions use rxd_s.
- 8-bit sample counter:
  - increments only on clk edges with Rx_sample_ENABLE=1;
  - clears to 0 on every state transition and whenever Rx_EN=0.
- Bit index counter, 0..DATA_BITS-1, is used in DATA only.
- FSM:
  - IDLE: on Rx_sample_ENABLE with rxd_s=0 -> START. Clear Rx_PERROR/Rx_FERROR, latch parity_odd.
  - START: when counter reaches OVERSAMPLE/2-1 on an enable:
    - rxd_s=0 -> DATA;
    - rxd_s=1 (glitch) -> IDLE, no Rx_VALID.
  - DATA: on each enable with counter=OVERSAMPLE-1, shift rxd_s into the shift register MSB (LSB-first line order). Counter clears.
    - After bit DATA_BITS-1 -> PARITY if UART_RX_PARITY_EN is defined, else STOP.
  - PARITY: on counter=OVERSAMPLE-1 with enable, compute err = ^{shift, rxd_s} XOR parity_odd_latched -> STOP.
  - STOP: on counter=OVERSAMPLE-1 with enable:
    - Rx_DATA<=shift, Rx_PERROR<=err, Rx_FERROR<=~rxd_s, Rx_VALID<=1;
    - -> IDLE if rxd_s=1, else -> BREAK.
  - BREAK: wait for rxd_s=1 on an enable -> IDLE. This prevents a low line being re-read as a start bit.
- Rx_VALID is high for exactly one clk, the cycle after the stop-bit sample edge. Rx_DATA and the error flags hold until the next STOP completion or the next start detect.
- Latency: start-edge sample to Rx_VALID = OVERSAMPLE/2 + (DATA_BITS+P+1)*OVERSAMPLE enables, where P = 1 with parity, 0 without. This is 152 enables for 8N1 and 168 enables for 8E1.
- Rx_EN=0 mid-frame: abort to IDLE next clk. No Rx_VALID; outputs keep their last values.
- reset mid-frame: immediate return to reset values.
- Counter arithmetic is modulo 256. OVERSAMPLE<=32 guarantees no wrap inside a bit.
- Rx_sample_ENABLE held high continuously is legal: the FSM simply runs at clk rate.

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state exists, frame = start + DATA_BITS + parity + stop, Rx_PERROR reflects the parity check.
- Undefined: no PARITY state, frame = start + DATA_BITS + stop, Rx_PERROR tied to 0, parity_odd ignored.

Test Plan:
1. 8N1, OVERSAMPLE=16, enable every 4 clk, send 0xA5 with stop=1 -> one Rx_VALID pulse 152 enables after start detect, Rx_DATA=0xA5, Rx_PERROR=0, Rx_FERROR=0.
2. UART_RX_PARITY_EN, parity_odd=0, send 0x07 with parity bit 1 -> Rx_DATA=0x07, Rx_PERROR=0. Repeat with parity bit 0 -> Rx_PERROR=1.
3. Send 0x3C with stop bit=0 -> Rx_VALID pulse, Rx_DATA=0x3C, Rx_FERROR=1. FSM stays in BREAK while RxD low; no second Rx_VALID until RxD returns high and a new start arrives.
4. RxD low for 3 enables only (glitch) -> FSM returns to IDLE, no Rx_VALID, Rx_BUSY pulses then 0.
5. Assert reset during DATA bit 4 of 0xFF, release, then send 0x12 -> outputs all 0 during reset, next frame received as 0x12.
6. Drop Rx_EN to 0 mid-frame for 2 clk, reassert, send 0x81 back-to-back twice -> aborted frame produces no Rx_VALID, then two Rx_VALID pulses with Rx_DATA=0x81.

Source files
------------

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: qualifies the start bit, samples each bit at mid-bit and reports the word with one-clk Rx_VALID; no backpressure.
// Define UART_RX_PARITY_EN to add the parity bit and its check; otherwise Rx_PERROR stays 0 and parity_odd is ignored.
module uart_rx_controller #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx_EN,
    input  logic                 Rx_sample_ENABLE,
    input  logic                 parity_odd,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    localparam int             IW        = $clog2(DATA_BITS);
    localparam logic [7:0]     HALF_LAST = 8'(OVERSAMPLE / 2 - 1);
    localparam logic [7:0]     BIT_LAST  = 8'(OVERSAMPLE - 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(DATA_BITS - 1);

    state_t                 state_q;
    logic [1:0]             sync_q;
    logic [7:0]             cnt_q;
    logic [IW-1:0]          idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   rxd_s;
    logic                   mid_bit;

`ifdef UART_RX_PARITY_EN
    logic                   podd_q;
    logic                   perr_q;
`else
    logic                   parity_unused;
    assign parity_unused = parity_odd;
`endif

    assign rxd_s   = sync_q[1];
    assign mid_bit = Rx_sample_ENABLE && (cnt_q == BIT_LAST);
    assign Rx_BUSY = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RxD};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            idx_q     <= '0;
            shift_q   <= '0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            podd_q    <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            Rx_VALID <= 1'b0;
            if (!Rx_EN) begin
                state_q <= S_IDLE;
                cnt_q   <= 8'd0;
            end else begin
                if (Rx_sample_ENABLE) begin
                    cnt_q <= cnt_q + 8'd1;
                end
                case (state_q)
                    S_IDLE: begin
                        if (Rx_sample_ENABLE && !rxd_s) begin
                            state_q   <= S_START;
                            cnt_q     <= 8'd0;
                            Rx_PERROR <= 1'b0;
                            Rx_FERROR <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            podd_q    <= parity_odd;
`endif
                        end
                    end
                    // Half a bit in, a line that has gone back high was only a glitch.
                    S_START: begin
                        if (Rx_sample_ENABLE && (cnt_q == HALF_LAST)) begin
                            state_q <= rxd_s ? S_IDLE : S_DATA;
                            cnt_q   <= 8'd0;
                            idx_q   <= '0;
                        end
                    end
                    S_DATA: begin
                        if (mid_bit) begin
                            cnt_q   <= 8'd0;
                            shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
                            idx_q   <= idx_q + 1'b1;
                            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= S_PARITY;
`else
                                state_q <= S_STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (mid_bit) begin
                            cnt_q   <= 8'd0;
                            perr_q  <= ^{shift_q, rxd_s} ^ podd_q;
                            state_q <= S_STOP;
                        end
                    end
`endif
                    S_STOP: begin
                        if (mid_bit) begin
                            cnt_q     <= 8'd0;
                            Rx_DATA   <= shift_q;
                            Rx_FERROR <= ~rxd_s;
                            Rx_VALID  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            Rx_PERROR <= perr_q;
`endif
                            state_q   <= rxd_s ? S_IDLE : S_BREAK;
                        end
                    end
                    // A line held low after a bad stop must not look like a fresh start bit.
                    S_BREAK: begin
                        if (Rx_sample_ENABLE && rxd_s) begin
                            state_q <= S_IDLE;
                            cnt_q   <= 8'd0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Randomised bench for uart_rx_controller: frames are built from their bit rules and checked against a queue-based model.
module tb_uart_rx_controller;

    localparam int DB = 8;
    localparam int OS = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          Rx_EN;
    logic          en;
    logic          parity_odd;
    logic          RxD;
    logic [DB-1:0] Rx_DATA;
    logic          Rx_VALID;
    logic          Rx_PERROR;
    logic          Rx_FERROR;
    logic          Rx_BUSY;

    int total = 0;
    int bad   = 0;
    int div   = 4;
    int en_cnt = 0;
    bit busy_seen = 0;
    bit prev_v = 0;

    logic [DB-1:0] q_data[$];
    bit            q_perr[$];
    bit            q_ferr[$];
    int            q_cnt[$];

    uart_rx_controller #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk(clk), .reset(reset), .Rx_EN(Rx_EN), .Rx_sample_ENABLE(en),
        .parity_odd(parity_odd), .RxD(RxD), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
        .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR), .Rx_BUSY(Rx_BUSY)
    );

    always #5 clk = ~clk;

    initial begin
        int ph;
        ph = 0;
        en = 1'b0;
        forever begin
            @(negedge clk);
            ph++;
            if (ph >= div) ph = 0;
            en = (ph == 0);
        end
    end

    initial forever begin
        @(posedge clk);
        if (en) en_cnt++;
    end

    initial forever begin
        @(negedge clk);
        if (Rx_VALID === 1'b1) begin
            total++;
            if (prev_v !== 1'b0) begin
                bad++;
                $display("FAIL valid_width got=two-cycle pulse exp=one-cycle pulse");
            end
            q_data.push_back(Rx_DATA);
            q_perr.push_back(Rx_PERROR);
            q_ferr.push_back(Rx_FERROR);
            q_cnt.push_back(en_cnt);
        end
        prev_v = Rx_VALID;
        if (Rx_BUSY === 1'b1) busy_seen = 1;
    end

    task automatic wait_en(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!en) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        @(negedge clk);
        RxD = v;
        wait_en(n);
    endtask

    // Returns the enable count seen just after the start edge was driven.
    task automatic send_frame(input logic [DB-1:0] d, input bit pbit, input bit stopb, output int n0);
        wait_en(1);
        @(negedge clk);
        RxD = 1'b0;
        n0 = en_cnt;
        wait_en(OS);
        for (int i = 0; i < DB; i++) drive_bit(d[i], OS);
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit, OS);
`endif
        drive_bit(stopb, OS);
    endtask

    function automatic bit model_perr(input logic [DB-1:0] d, input bit pbit, input bit podd);
`ifdef UART_RX_PARITY_EN
        int ones;
        ones = $countones(d) + int'(pbit);
        return podd ? (ones % 2 == 0) : (ones % 2 == 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit good_parity(input logic [DB-1:0] d, input bit podd);
        return (($countones(d) % 2) == 1) ^ podd;
    endfunction

    task automatic pop_frame(output logic [DB-1:0] d, output bit pe, output bit fe, output int c);
        if (q_data.size() == 0) begin
            d = '0; pe = 0; fe = 0; c = -1;
        end else begin
            d = q_data.pop_front(); pe = q_perr.pop_front();
            fe = q_ferr.pop_front(); c = q_cnt.pop_front();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; Rx_EN = 1'b1; RxD = 1'b1; parity_odd = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (Rx_DATA !== '0)   begin bad++; $display("FAIL reset_data got=%h exp=00", Rx_DATA); end
        total++; if (Rx_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", Rx_VALID); end
        total++; if (Rx_PERROR !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", Rx_PERROR); end
        total++; if (Rx_FERROR !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", Rx_FERROR); end
        total++; if (Rx_BUSY !== 1'b0)  begin bad++; $display("FAIL reset_busy got=%b exp=0", Rx_BUSY); end
        reset = 1'b0;
        wait_en(4);
    endtask

    task automatic test_basic;
        logic [DB-1:0] d; bit pe, fe; int c, n0;
        parity_odd = 1'b0;
        send_frame(8'hA5, good_parity(8'hA5, 1'b0), 1'b1, n0);
        wait_en(4);
        total++; if (q_data.size() !== 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", q_data.size()); end
        pop_frame(d, pe, fe, c);
        total++; if (d !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", d); end
        total++; if (pe !== 1'b0) begin bad++; $display("FAIL basic_perr got=%b exp=0", pe); end
        total++; if (fe !== 1'b0) begin bad++; $display("FAIL basic_ferr got=%b exp=0", fe); end
        // Start detect is the first enable after the edge; VALID follows OS/2 + (DB+P+1)*OS enables later.
`ifdef UART_RX_PARITY_EN
        total++; if (c !== n0 + 1 + OS/2 + (DB + 2) * OS) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", c - n0 - 1, OS/2 + (DB + 2) * OS); end
`else
        total++; if (c !== n0 + 1 + OS/2 + (DB + 1) * OS) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", c - n0 - 1, OS/2 + (DB + 1) * OS); end
`endif
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        logic [DB-1:0] d; bit pe, fe; int c, n0;
        bit pb[3]   = '{1'b1, 1'b0, 1'b0};
        bit po[3]   = '{1'b0, 1'b0, 1'b1};
        bit exp_[3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            parity_odd = po[i];
            send_frame(8'h07, pb[i], 1'b1, n0);
            wait_en(4);
            pop_frame(d, pe, fe, c);
            total++; if (d !== 8'h07) begin bad++; $display("FAIL parity_data[%0d] got=%h exp=07", i, d); end
            total++; if (pe !== exp_[i]) begin bad++; $display("FAIL parity_perr[%0d] got=%b exp=%b", i, pe, exp_[i]); end
        end
    endtask
`endif

    task automatic test_random_frames(input int n);
        logic [DB-1:0] d, tx; bit pe, fe, pb, podd, stopb; int c, n0;
        for (int i = 0; i < n; i++) begin
            tx    = DB'($urandom);
            podd  = 1'($urandom);
            pb    = ($urandom_range(0, 2) == 0) ? ~good_parity(tx, podd) : good_parity(tx, podd);
            stopb = ($urandom_range(0, 3) != 0);
            parity_odd = podd;
            send_frame(tx, pb, stopb, n0);
            if (!stopb) drive_bit(1'b1, 4);
            wait_en(4);
            total++; if (q_data.size() !== 1) begin bad++; $display("FAIL rand_count[%0d] got=%0d exp=1", i, q_data.size()); end
            pop_frame(d, pe, fe, c);
            total++; if (d !== tx) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, d, tx); end
            total++; if (pe !== model_perr(tx, pb, podd)) begin bad++; $display("FAIL rand_perr[%0d] got=%b exp=%b", i, pe, model_perr(tx, pb, podd)); end
            total++; if (fe !== ~stopb) begin bad++; $display("FAIL rand_ferr[%0d] got=%b exp=%b", i, fe, ~stopb); end
        end
    endtask

    task automatic test_framing;
        logic [DB-1:0] d; bit pe, fe; int c, n0;
        parity_odd = 1'b0;
        send_frame(8'h3C, good_parity(8'h3C, 1'b0), 1'b0, n0);
        wait_en(4);
        total++; if (q_data.size() !== 1) begin bad++; $display("FAIL brk_count got=%0d exp=1", q_data.size()); end
        pop_frame(d, pe, fe, c);
        total++; if (d !== 8'h3C) begin bad++; $display("FAIL brk_data got=%h exp=3c", d); end
        total++; if (fe !== 1'b1) begin bad++; $display("FAIL brk_ferr got=%b exp=1", fe); end
        wait_en(3 * OS);
        total++; if (Rx_BUSY !== 1'b1) begin bad++; $display("FAIL brk_hold_busy got=%b exp=1", Rx_BUSY); end
        total++; if (q_data.size() !== 0) begin bad++; $display("FAIL brk_no_valid got=%0d exp=0", q_data.size()); end
        drive_bit(1'b1, 8);
        total++; if (Rx_BUSY !== 1'b0) begin bad++; $display("FAIL brk_exit_busy got=%b exp=0", Rx_BUSY); end
        total++; if (q_data.size() !== 0) begin bad++; $display("FAIL brk_exit_valid got=%0d exp=0", q_data.size()); end
    endtask

    task automatic test_glitch;
        wait_en(2);
        busy_seen = 0;
        drive_bit(1'b0, 3);
        drive_bit(1'b1, 20);
        total++; if (busy_seen !== 1'b1) begin bad++; $display("FAIL glitch_busy_pulse got=%b exp=1", busy_seen); end
        total++; if (Rx_BUSY !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b exp=0", Rx_BUSY); end
        total++; if (q_data.size() !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", q_data.size()); end
    endtask

    task automatic test_reset_midframe;
        logic [DB-1:0] d; bit pe, fe; int c, n0;
        drive_bit(1'b0, OS);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, OS);
        drive_bit(1'b1, 8);
        total++; if (Rx_BUSY !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1", Rx_BUSY); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (Rx_BUSY !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", Rx_BUSY); end
        total++; if (Rx_DATA !== '0) begin bad++; $display("FAIL rstmid_data got=%h exp=00", Rx_DATA); end
        total++; if ({Rx_VALID, Rx_PERROR, Rx_FERROR} !== 3'b000) begin bad++; $display("FAIL rstmid_flags got=%b exp=000", {Rx_VALID, Rx_PERROR, Rx_FERROR}); end
        @(negedge clk);
        reset = 1'b0;
        wait_en(4);
        parity_odd = 1'b1;
        send_frame(8'h12, good_parity(8'h12, 1'b1), 1'b1, n0);
        wait_en(4);
        total++; if (q_data.size() !== 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", q_data.size()); end
        pop_frame(d, pe, fe, c);
        total++; if (d !== 8'h12) begin bad++; $display("FAIL rstmid_next got=%h exp=12", d); end
    endtask

    task automatic test_back_to_back;
        logic [DB-1:0] d; bit pe, fe; int c, n0;
        parity_odd = 1'b0;
        drive_bit(1'b0, OS);
        drive_bit(1'b1, OS);
        drive_bit(1'b0, OS);
        drive_bit(1'b1, 6);
        @(negedge clk);
        Rx_EN = 1'b0;
        @(negedge clk);
        total++; if (Rx_BUSY !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", Rx_BUSY); end
        @(negedge clk);
        Rx_EN = 1'b1;
        total++; if (Rx_DATA !== 8'h12) begin bad++; $display("FAIL abort_keep_data got=%h exp=12", Rx_DATA); end
        wait_en(12 * OS);
        total++; if (q_data.size() !== 0) begin bad++; $display("FAIL abort_valid got=%0d exp=0", q_data.size()); end
        send_frame(8'h81, good_parity(8'h81, 1'b0), 1'b1, n0);
        send_frame(8'h81, good_parity(8'h81, 1'b0), 1'b1, n0);
        wait_en(4);
        total++; if (q_data.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", q_data.size()); end
        for (int i = 0; i < 2; i++) begin
            pop_frame(d, pe, fe, c);
            total++; if (d !== 8'h81) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=81", i, d); end
            total++; if (fe !== 1'b0) begin bad++; $display("FAIL b2b_ferr[%0d] got=%b exp=0", i, fe); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        test_random_frames(8);
        test_framing;
        test_glitch;
        test_reset_midframe;
        test_back_to_back;
        div = 1;
        wait_en(8);
        test_random_frames(8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
